// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-transfer master: one command in flight, REQ->STB 1 cycle, DONE/ERR one cycle after ACK/ERR; requester waits on BUSY.
// Optional watchdog abort when WB_MASTER_TIMEOUT_EN is defined; otherwise BUS waits indefinitely and TMO_OUTPUT stays 0.
module wb_master_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  REQ_INPUT,
    input  logic                  WE_INPUT,
    input  logic [ADDR_WIDTH-1:0] ADR_INPUT,
    input  logic [DATA_WIDTH-1:0] DATA_INPUT,
    output logic                  BUSY_OUTPUT,
    output logic                  DONE_OUTPUT,
    output logic                  ERR_OUTPUT,
    output logic                  TMO_OUTPUT,
    output logic [DATA_WIDTH-1:0] DATA_OUTPUT,
    output logic                  CYC_O,
    output logic                  STB_O,
    output logic                  WE_O,
    output logic [ADDR_WIDTH-1:0] ADR_O,
    output logic [DATA_WIDTH-1:0] DAT_O,
    input  logic [DATA_WIDTH-1:0] DAT_I,
    input  logic                  ACK_I,
    input  logic                  ERR_I
);

    typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_tmo;
    logic                  w_bus;
    logic                  w_timeout;
    logic                  w_accept;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign w_accept = (r_state == S_IDLE) && REQ_INPUT;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wd_cnt;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_wd_cnt <= 8'd0;
        end else if (w_accept) begin
            r_wd_cnt <= 8'd0;
        end else if (r_state == S_BUS && !ACK_I && !ERR_I) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end
    end

    // Expires at the edge where the count would reach TIMEOUT_CYCLES.
    assign w_timeout = (r_wd_cnt == LP_WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (REQ_INPUT) w_next = S_BUS;
            S_BUS:  if (ERR_I || ACK_I || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bus = 1'b0;
        if (r_state == S_BUS) w_bus = 1'b1;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_tmo  <= 1'b0;
            if (w_accept) begin
                r_we  <= WE_INPUT;
                r_adr <= ADR_INPUT;
                r_dat <= DATA_INPUT;
            end
            if (r_state == S_BUS) begin
                // ERR outranks ACK, and ACK outranks a watchdog expiry on the same edge.
                if (ERR_I) begin
                    r_err <= 1'b1;
                end else if (ACK_I) begin
                    r_done <= 1'b1;
                    if (!r_we) r_rdata <= DAT_I;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                    r_tmo <= 1'b1;
                end
            end
        end
    end

    assign CYC_O       = w_bus;
    assign STB_O       = w_bus;
    assign BUSY_OUTPUT = w_bus;
    assign WE_O        = r_we;
    assign ADR_O       = r_adr;
    assign DAT_O       = r_dat;
    assign DATA_OUTPUT = r_rdata;
    assign DONE_OUTPUT = r_done;
    assign ERR_OUTPUT  = r_err;
    assign TMO_OUTPUT  = r_tmo;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Randomized scoreboard bench for wb_master_ctrl: driver queues expected completions, negedge monitor pops and compares.
module tb_wb_master_ctrl;
    localparam int DW  = 64;
    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          CLK_I;
    logic          RST_I;
    logic          REQ_INPUT;
    logic          WE_INPUT;
    logic [AW-1:0] ADR_INPUT;
    logic [DW-1:0] DATA_INPUT;
    logic          BUSY_OUTPUT;
    logic          DONE_OUTPUT;
    logic          ERR_OUTPUT;
    logic          TMO_OUTPUT;
    logic [DW-1:0] DATA_OUTPUT;
    logic          CYC_O;
    logic          STB_O;
    logic          WE_O;
    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I;
    logic          ACK_I;
    logic          ERR_I;

    wb_master_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .REQ_INPUT(REQ_INPUT), .WE_INPUT(WE_INPUT),
        .ADR_INPUT(ADR_INPUT), .DATA_INPUT(DATA_INPUT), .BUSY_OUTPUT(BUSY_OUTPUT),
        .DONE_OUTPUT(DONE_OUTPUT), .ERR_OUTPUT(ERR_OUTPUT), .TMO_OUTPUT(TMO_OUTPUT),
        .DATA_OUTPUT(DATA_OUTPUT), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          done;
        bit          err;
        bit          tmo;
        logic [63:0] rdata;
        int          stb;
        logic        we;
        logic [7:0]  adr;
        logic [63:0] dat;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_rdata;

    function automatic void push_exp(input logic we, input logic [7:0] adr, input logic [63:0] dat,
                                     input int stb, input bit done, input bit err, input bit tmo);
        exp_t x;
        x.we = we; x.adr = adr; x.dat = dat; x.stb = stb;
        x.done = done; x.err = err; x.tmo = tmo; x.rdata = model_rdata;
        sb_q.push_back(x);
    endfunction

    // Monitor: counts strobe cycles and checks each completion pulse against the queue head.
    int          mon_stb = 0;
    logic        mon_we;
    logic [7:0]  mon_adr;
    logic [63:0] mon_dat;
    exp_t        mon_e;

    always @(negedge CLK_I) begin
        if (STB_O) begin
            if (mon_stb == 0) begin
                mon_we = WE_O; mon_adr = ADR_O; mon_dat = DAT_O;
            end else begin
                chk("adr_stable", ADR_O, mon_adr);
                chk("dat_stable", DAT_O, mon_dat);
                chk("we_stable", WE_O, mon_we);
            end
            mon_stb++;
        end
        if (DONE_OUTPUT || ERR_OUTPUT || TMO_OUTPUT) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse done=%b err=%b tmo=%b required no pulse at %0t",
                         DONE_OUTPUT, ERR_OUTPUT, TMO_OUTPUT, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done", DONE_OUTPUT, mon_e.done);
                chk("err", ERR_OUTPUT, mon_e.err);
                chk("tmo", TMO_OUTPUT, mon_e.tmo);
                chk("rdata", DATA_OUTPUT, mon_e.rdata);
                chk("stb_cycles", mon_stb, mon_e.stb);
                chk("bus_we", mon_we, mon_e.we);
                chk("bus_adr", mon_adr, mon_e.adr);
                chk("bus_dat", mon_dat, mon_e.dat);
                chk("busy_in_pulse", BUSY_OUTPUT, 1'b0);
                chk("stb_in_pulse", STB_O, 1'b0);
            end
            mon_stb = 0;
        end else if (!STB_O) begin
            mon_stb = 0;
        end
    end

    // Issues one command and plays the slave; resp 0=ACK 1=ERR 2=ACK+ERR 3=never respond.
    task automatic txn(input logic we, input logic [7:0] adr, input logic [63:0] dat,
                       input logic [63:0] dati, input int waits, input int resp);
        bit to;
        bit done;
        bit err;
`ifdef WB_MASTER_TIMEOUT_EN
        to = (resp == 3) || (waits >= TMO);
`else
        to = 1'b0;
`endif
        done = 1'b0;
        err  = 1'b0;
        if (to) err = 1'b1;
        else if (resp == 1 || resp == 2) err = 1'b1;
        else begin
            done = 1'b1;
            if (!we) model_rdata = dati;
        end
        push_exp(we, adr, dat, to ? TMO : waits + 1, done, err, to);

        REQ_INPUT = 1'b1; WE_INPUT = we; ADR_INPUT = adr; DATA_INPUT = dat;
        @(posedge CLK_I); #1;
        chk("req_to_stb", STB_O, 1'b1);
        REQ_INPUT = 1'b0; WE_INPUT = ~we; ADR_INPUT = $urandom; DATA_INPUT = {$urandom, $urandom};
        for (int i = 0; i < waits; i++) begin
            ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = {$urandom, $urandom};
            @(posedge CLK_I); #1;
        end
        DAT_I = dati;
        ACK_I = (resp == 0 || resp == 2);
        ERR_I = (resp == 1 || resp == 2);
        @(posedge CLK_I); #1;
        ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = {$urandom, $urandom};
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    logic [3:0]  pat;
    int          r;
    int          w;
    int          rs;
    logic [63:0] d0;

    initial begin
        RST_I = 1'b1; REQ_INPUT = 1'b0; WE_INPUT = 1'b0; ADR_INPUT = '0; DATA_INPUT = '0;
        DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
        model_rdata = '0;
        repeat (3) @(posedge CLK_I);
        #1;
        chk("rst_cyc", CYC_O, 1'b0);
        chk("rst_stb", STB_O, 1'b0);
        chk("rst_busy", BUSY_OUTPUT, 1'b0);
        chk("rst_done", DONE_OUTPUT, 1'b0);
        chk("rst_err", ERR_OUTPUT, 1'b0);
        chk("rst_tmo", TMO_OUTPUT, 1'b0);
        chk("rst_we", WE_O, 1'b0);
        chk("rst_adr", ADR_O, 8'h00);
        chk("rst_dat", DAT_O, 64'h0);
        chk("rst_rdata", DATA_OUTPUT, 64'h0);
        RST_I = 1'b0;
        @(posedge CLK_I); #1;

        txn(1'b1, 8'hB6, 64'h123ababaabcdef90, 64'hdeadbeefdeadbeef, 0, 0);
        @(posedge CLK_I); #1;
        chk("write_no_rdata", DATA_OUTPUT, 64'h0);

        txn(1'b0, 8'hC6, 64'h0, 64'h1234567812345678, 3, 0);
        @(posedge CLK_I); #1;
        chk("read_holds", DATA_OUTPUT, 64'h1234567812345678);

        txn(1'b0, 8'h17, 64'h0, 64'habcdefabcdefabcd, 1, 2);
        @(posedge CLK_I); #1;
        chk("err_keeps_rdata", DATA_OUTPUT, 64'h1234567812345678);

        // Terminations while idle must be ignored.
        ACK_I = 1'b1; ERR_I = 1'b1; DAT_I = 64'h5555aaaa5555aaaa;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK_I); #1;
            chk("idle_ack_done", DONE_OUTPUT, 1'b0);
            chk("idle_ack_err", ERR_OUTPUT, 1'b0);
            chk("idle_ack_stb", STB_O, 1'b0);
        end
        ACK_I = 1'b0; ERR_I = 1'b0;

        // Back-to-back with REQ held and a zero-wait slave.
        push_exp(1'b1, 8'h33, 64'h0f0f0f0f0f0f0f0f, 1, 1'b1, 1'b0, 1'b0);
        push_exp(1'b1, 8'h33, 64'h0f0f0f0f0f0f0f0f, 1, 1'b1, 1'b0, 1'b0);
        REQ_INPUT = 1'b1; WE_INPUT = 1'b1; ADR_INPUT = 8'h33; DATA_INPUT = 64'h0f0f0f0f0f0f0f0f; ACK_I = 1'b1;
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK_I); #1;
            chk("b2b_stb", STB_O, pat[i]);
        end
        REQ_INPUT = 1'b0; ACK_I = 1'b0;
        @(posedge CLK_I); #1;
        chk("b2b_idle", STB_O, 1'b0);

        // Reset on the second strobe cycle of a read, REQ held across it.
        REQ_INPUT = 1'b1; WE_INPUT = 1'b0; ADR_INPUT = 8'hAA; DATA_INPUT = 64'h1;
        @(posedge CLK_I); #1;
        chk("rst_mid_stb1", STB_O, 1'b1);
        @(posedge CLK_I); #1;
        chk("rst_mid_stb2", STB_O, 1'b1);
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        chk("rst_mid_stb", STB_O, 1'b0);
        chk("rst_mid_busy", BUSY_OUTPUT, 1'b0);
        chk("rst_mid_done", DONE_OUTPUT, 1'b0);
        chk("rst_mid_err", ERR_OUTPUT, 1'b0);
        chk("rst_mid_adr", ADR_O, 8'h00);
        chk("rst_mid_rdata", DATA_OUTPUT, 64'h0);
        model_rdata = '0;
        RST_I = 1'b0;
        txn(1'b0, 8'h5A, 64'h2, 64'h0123456789abcdef, 0, 0);
        @(posedge CLK_I); #1;

`ifdef WB_MASTER_TIMEOUT_EN
        txn(1'b0, 8'h71, 64'h0, 64'h1111, 20, 3);
        @(posedge CLK_I); #1;
        txn(1'b0, 8'h72, 64'h0, 64'h2222, TMO - 1, 0);
        @(posedge CLK_I); #1;
        txn(1'b1, 8'h73, 64'h3, 64'h3333, TMO, 0);
        @(posedge CLK_I); #1;
`else
        txn(1'b0, 8'h71, 64'h0, 64'h4444444444444444, 110, 0);
        @(posedge CLK_I); #1;
`endif

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            rs = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
`ifdef WB_MASTER_TIMEOUT_EN
            w = $urandom_range(0, 20);
`else
            w = $urandom_range(0, 6);
            if (rs == 3) rs = 0;
`endif
            d0 = {$urandom, $urandom};
            txn(1'($urandom_range(0, 1)), 8'($urandom), d0, {$urandom, $urandom}, w, rs);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK_I); #1;
            end
        end

        repeat (4) @(posedge CLK_I);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_master_ctrl.md
# wb_master_ctrl

Wishbone classic single-transfer bus master that sits directly upstream of `wishbone_intercon`. It accepts one read or write command at a time from a local requester and runs the CYC/STB/ACK handshake toward the interconnect's master port. It returns read data and a completion or error pulse to the requester. An optional watchdog aborts cycles that the slave never terminates.

## Interface
- `DATA_WIDTH`, default 64: data bus width.
- `ADDR_WIDTH`, default 8: address bus width.
- `TIMEOUT_CYCLES`, default 16: watchdog limit in cycles; legal range 1–255.

Ports:
- `CLK_I` in 1: the single clock; every register updates on its rising edge.
- `RST_I` in 1: synchronous, active-high reset.
- `REQ_INPUT` in 1: command request; sampled only in IDLE.
- `WE_INPUT` in 1: 1 = write, 0 = read; captured with the request.
- `ADR_INPUT` in ADDR_WIDTH: command address; captured with the request.
- `DATA_INPUT` in DATA_WIDTH: write data; captured with the request.
- `BUSY_OUTPUT` out 1: high while a bus cycle is in progress.
- `DONE_OUTPUT` out 1: one-cycle pulse; transfer terminated with ACK.
- `ERR_OUTPUT` out 1: one-cycle pulse; transfer terminated with ERR or by timeout.
- `TMO_OUTPUT` out 1: one-cycle pulse, coincident with `ERR_OUTPUT`, when the cause was a timeout.
- `DATA_OUTPUT` out DATA_WIDTH: read data; holds until the next read completes.
- `CYC_O`, `STB_O`, `WE_O` out 1 each: Wishbone master strobes.
- `ADR_O` out ADDR_WIDTH: Wishbone address.
- `DAT_O` out DATA_WIDTH: Wishbone write data.
- `DAT_I` in DATA_WIDTH: Wishbone read data.
- `ACK_I`, `ERR_I` in 1 each: Wishbone slave terminations.

## Operation
State machine states:
- **IDLE:** `CYC_O` = `STB_O` = 0. When `REQ_INPUT` = 1 at a clock edge:
  - latch `WE_INPUT`, `ADR_INPUT` and `DATA_INPUT` into `WE_O`, `ADR_O` and `DAT_O`;
  - clear the watchdog counter;
  - go to BUS.
- **BUS:** `CYC_O` = `STB_O` = `BUSY_OUTPUT` = 1. `WE_O`, `ADR_O` and `DAT_O` stay stable for the whole cycle. At each edge:
  - **`ERR_I` = 1:** `ERR_OUTPUT` pulses; go to IDLE. ERR has priority over a simultaneous ACK; `DATA_OUTPUT` is not updated.
  - **`ACK_I` = 1 (and `ERR_I` = 0):** `DONE_OUTPUT` pulses. If `WE_O` = 0, `DATA_OUTPUT` ← `DAT_I` at the same edge. Go to IDLE.
  - **Neither:** increment the watchdog counter; stay in BUS.

Boundary rules:
- `REQ_INPUT` is ignored outside IDLE. There is no queueing; the requester must wait for `BUSY_OUTPUT` = 0.
- `WE_O`, `ADR_O` and `DAT_O` hold their last values in IDLE. Only `CYC_O`/`STB_O` qualify them.
- `ACK_I`/`ERR_I` arriving while in IDLE are ignored and produce no pulse.
- `DONE_OUTPUT` and `ERR_OUTPUT` are never high in the same cycle.
- Write data in `DAT_O` never reaches `DATA_OUTPUT`.

Reset (`RST_I` = 1 at an edge, any state):
- State goes to IDLE; all outputs go to 0, including `DATA_OUTPUT` and the address/data registers.
- Reset mid-cycle drops `CYC_O`/`STB_O` at that edge and produces no DONE/ERR pulse.
- Reset has priority over `REQ_INPUT`, `ACK_I` and `ERR_I`.

## Timing
- **Request to strobe:** `REQ_INPUT` sampled at edge N → `CYC_O`/`STB_O` high in the cycle following edge N.
- **Termination:** ACK/ERR sampled at edge M → strobes low and `DONE_OUTPUT`/`ERR_OUTPUT` high in the cycle after edge M, for exactly one cycle.
- **Zero-wait slave:** a transfer takes one STB cycle. A new `REQ_INPUT` is accepted at the edge ending the DONE cycle, giving a 2-cycle minimum issue interval.
- **Wait states:** each cycle without ACK/ERR extends the STB phase by one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`WB_MASTER_TIMEOUT_EN` defined:**
  - The watchdog counter (8 bits) is compiled in.
  - If the counter reaches `TIMEOUT_CYCLES` − 1 and no ACK/ERR is seen at the edge where it would reach `TIMEOUT_CYCLES`, the FSM goes to IDLE.
  - At that point `ERR_OUTPUT` and `TMO_OUTPUT` pulse together.
  - Result: `STB_O` is high for at most `TIMEOUT_CYCLES` cycles.
  - An ACK arriving on the same edge as the expiry wins, and the transfer completes normally.
- **Not defined:**
  - No counter logic exists and BUS waits indefinitely.
  - `TMO_OUTPUT` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- **Zero-wait write:** write to `ADR_INPUT`=8'hB6 with `DATA_INPUT`=64'h123ababaabcdef90, ACK returned in the first STB cycle → `ADR_O`=8'hB6, `DAT_O`=64'h123ababaabcdef90, `WE_O`=1 for exactly 1 STB cycle, then one `DONE_OUTPUT` pulse; `DATA_OUTPUT` stays 0.
- **Read with 3 wait states:** read of 8'hC6, ACK held off 3 cycles, `DAT_I`=64'h1234567812345678 → STB high for 4 cycles, `DATA_OUTPUT`=64'h1234567812345678 in the DONE cycle and afterwards.
- **ACK and ERR together:** `ACK_I`=`ERR_I`=1 on the same edge during a read with `DAT_I`=64'habcdefabcdefabcd → `ERR_OUTPUT` pulses, no DONE, `DATA_OUTPUT` unchanged.
- **Timeout:** macro on, `TIMEOUT_CYCLES`=16, slave never responds → STB high for exactly 16 cycles, then `ERR_OUTPUT`=`TMO_OUTPUT`=1 for one cycle, `BUSY_OUTPUT`=0. With the macro off, STB stays high for more than 100 cycles.
- **Reset mid-cycle:** `RST_I` asserted on the 2nd STB cycle → at that edge all outputs go to 0 and no pulses occur; with `REQ_INPUT` held, a new request is accepted at the first edge after `RST_I` deasserts.
- **Back-to-back:** `REQ_INPUT` held high with a zero-wait slave → strobes alternate 1,0,1,0; two DONE pulses within 4 cycles; `REQ_INPUT` is ignored while `BUSY_OUTPUT`=1.
